// File: rtl/ixc_cap_loop_pkg.sv
// Shared types and helpers for the capture-loop arbiter.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: none.
package ixc_cap_loop_pkg;

    localparam int NCH_MAX = 16;
    localparam int PTR_W   = $clog2(NCH_MAX);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        GAP   = 3'd2,
        LATCH = 3'd3,
        HALT  = 3'd4
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, wrapping past the top.
    // Unused upper request bits must be zero so the wrap skips them.
    function automatic rr_pick_t rr_pick(input logic [NCH_MAX-1:0] req,
                                         input logic [PTR_W-1:0]   ptr);
        rr_pick_t         res;
        logic [PTR_W-1:0] cand;
        res = '0;
        for (int i = 0; i < NCH_MAX; i++) begin
            cand = ptr + PTR_W'(i);
            if (!res.valid && req[cand]) begin
                res.valid = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ixc_cap_loop_rr_pick.sv
// Round-robin picker: lowest requesting channel at or after ptr, with wrap.
// Latency: combinational.
// Backpressure: none; result follows inputs every cycle.
module ixc_cap_loop_rr_pick
    import ixc_cap_loop_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int IDX_W = 2
) (
    input  logic [NCH-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    rr_pick_t res;

    // Widen to the package picker width and narrow the result back.
    always_comb begin
        res = rr_pick(NCH_MAX'(req), PTR_W'(ptr));
        vld = res.valid;
        idx = IDX_W'(res.idx);
    end

endmodule

// File: rtl/ixc_cap_loop_arb.sv
// Capture-loop controller: stalls emulated clock while channels pend, serves them round-robin, latches once.
// Latency: grant one cycle after en in IDLE; bcLatchEn LATCH_DLY+1 cycles after the last done.
// Backpressure: bpWait holds the emulated clock; optional svcCnt port under CAP_LOOP_STATS_EN.
module ixc_cap_loop_arb
    import ixc_cap_loop_pkg::*;
#(
    parameter  int NCH       = 4,
    parameter  int TMO_W     = 16,
    parameter  int LATCH_DLY = 2,
    localparam int IDX_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             bClk,
    input  logic             bRst,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   done,
    input  logic [TMO_W-1:0] tmoLimit,
    output logic [NCH-1:0]   grant,
    output logic             bpWait,
    output logic             bcLatchEn,
    output logic             bpHalt,
    output logic [IDX_W-1:0] tmoCh
`ifdef CAP_LOOP_STATS_EN
    ,
    output logic [31:0]      svcCnt
`endif
);

    state_e           state;
    logic [IDX_W-1:0] rrPtr;
    logic [IDX_W-1:0] curCh;
    logic [TMO_W-1:0] svcTmr;
    logic [2:0]       gapCnt;

    logic             curDone;
    logic             curEn;
    logic             tmoHit;
    logic [IDX_W-1:0] nextPtr;
    logic [NCH-1:0]   pickReq;
    logic [IDX_W-1:0] pickPtr;
    logic             pickVld;
    logic [IDX_W-1:0] pickIdx;

    function automatic logic [NCH-1:0] toOneHot(input logic [IDX_W-1:0] i);
        logic [NCH-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Current-service status; while serving, the picker looks past the granted channel.
    always_comb begin
        curDone = done[curCh];
        curEn   = en[curCh];
        nextPtr = (curCh == IDX_W'(NCH - 1)) ? '0 : curCh + IDX_W'(1);
        tmoHit  = (tmoLimit != '0) && (svcTmr == tmoLimit - TMO_W'(1)) && !curDone;
        if (state == SERVE) begin
            pickReq = en & ~grant;
            pickPtr = nextPtr;
        end else begin
            pickReq = en;
            pickPtr = rrPtr;
        end
    end

    ixc_cap_loop_rr_pick #(
        .NCH   (NCH),
        .IDX_W (IDX_W)
    ) uPick (
        .req (pickReq),
        .ptr (pickPtr),
        .vld (pickVld),
        .idx (pickIdx)
    );

    // Main control FSM with registered grant/stall/latch/halt outputs.
    always_ff @(posedge bClk) begin
        if (bRst) begin
            state     <= IDLE;
            rrPtr     <= '0;
            curCh     <= '0;
            svcTmr    <= '0;
            gapCnt    <= '0;
            grant     <= '0;
            bpWait    <= 1'b0;
            bcLatchEn <= 1'b0;
            bpHalt    <= 1'b0;
            tmoCh     <= '0;
        end else begin
            bcLatchEn <= 1'b0;
            case (state)
                IDLE: begin
                    if (pickVld) begin
                        state  <= SERVE;
                        curCh  <= pickIdx;
                        grant  <= toOneHot(pickIdx);
                        svcTmr <= '0;
                        bpWait <= 1'b1;
                    end
                end
                SERVE: begin
                    svcTmr <= svcTmr + TMO_W'(1);
                    if (tmoHit) begin
                        state  <= HALT;
                        grant  <= '0;
                        bpHalt <= 1'b1;
                        tmoCh  <= curCh;
                    end else if (curDone || !curEn) begin
                        rrPtr <= nextPtr;
                        if (pickVld) begin
                            curCh  <= pickIdx;
                            grant  <= toOneHot(pickIdx);
                            svcTmr <= '0;
                        end else begin
                            grant <= '0;
                            if (LATCH_DLY == 0) begin
                                state     <= LATCH;
                                bcLatchEn <= 1'b1;
                            end else begin
                                state  <= GAP;
                                gapCnt <= '0;
                            end
                        end
                    end
                end
                GAP: begin
                    // A late request is served first; the latch is deferred until it ends.
                    if (pickVld) begin
                        state  <= SERVE;
                        curCh  <= pickIdx;
                        grant  <= toOneHot(pickIdx);
                        svcTmr <= '0;
                    end else if (gapCnt == 3'(LATCH_DLY - 1)) begin
                        state     <= LATCH;
                        bcLatchEn <= 1'b1;
                    end else begin
                        gapCnt <= gapCnt + 3'd1;
                    end
                end
                LATCH: begin
                    state  <= IDLE;
                    bpWait <= 1'b0;
                end
                HALT: begin
                    bpWait <= 1'b1;
                    bpHalt <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CAP_LOOP_STATS_EN
    // Count services that ended with done; aborts and timeouts are excluded.
    always_ff @(posedge bClk) begin
        if (bRst) begin
            svcCnt <= '0;
        end else if (state == SERVE && curDone) begin
            svcCnt <= svcCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ixc_cap_loop_arb.sv
// Directed bench for ixc_cap_loop_arb (NCH=4, TMO_W=16, LATCH_DLY=2).
// Latency: inputs driven 1ns after posedge; outputs checked 1ns after the next posedge.
// Backpressure: none modelled; en/done are driven as the capture engines would.
module tb_ixc_cap_loop_arb;

    logic        bClk = 1'b0;
    logic        bRst = 1'b1;
    logic [3:0]  en = '0;
    logic [3:0]  done = '0;
    logic [15:0] tmoLimit = '0;
    logic [3:0]  grant;
    logic        bpWait;
    logic        bcLatchEn;
    logic        bpHalt;
    logic [1:0]  tmoCh;
`ifdef CAP_LOOP_STATS_EN
    logic [31:0] svcCnt;
`endif

    int nTests = 0;
    int nFails = 0;
    int latchCnt = 0;
    int latchBase;

    ixc_cap_loop_arb #(
        .NCH       (4),
        .TMO_W     (16),
        .LATCH_DLY (2)
    ) dut (
        .bClk      (bClk),
        .bRst      (bRst),
        .en        (en),
        .done      (done),
        .tmoLimit  (tmoLimit),
        .grant     (grant),
        .bpWait    (bpWait),
        .bcLatchEn (bcLatchEn),
        .bpHalt    (bpHalt),
        .tmoCh     (tmoCh)
`ifdef CAP_LOOP_STATS_EN
        ,
        .svcCnt    (svcCnt)
`endif
    );

    always #5 bClk = ~bClk;

    // Count latch pulses mid-cycle, away from the sampling edge.
    always @(negedge bClk) begin
        if (bcLatchEn === 1'b1) latchCnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge bClk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic doReset();
        bRst = 1'b1;
        en   = '0;
        done = '0;
        tick();
        tick();
        bRst = 1'b0;
        latchBase = latchCnt;
    endtask

    initial begin
        // Reset state
        ticks(2);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_bpWait", 32'(bpWait), 32'h0);
        check("rst_latch", 32'(bcLatchEn), 32'h0);
        check("rst_halt", 32'(bpHalt), 32'h0);
        check("rst_tmoCh", 32'(tmoCh), 32'h0);
        bRst = 1'b0;
        latchBase = latchCnt;

        // T1: single channel, done on the 4th grant cycle; stray done on ch1 ignored
        en = 4'b0001;
        tick();
        check("t1_grant_c0", 32'(grant), 32'h1);
        check("t1_wait_c0", 32'(bpWait), 32'h1);
        done = 4'b0010;
        tick();
        done = 4'b0000;
        check("t1_grant_c1", 32'(grant), 32'h1);
        tick();
        check("t1_grant_c2", 32'(grant), 32'h1);
        tick();
        check("t1_grant_c3", 32'(grant), 32'h1);
        done = 4'b0001;
        tick();
        done = 4'b0000;
        en   = 4'b0000;
        check("t1_grant_c4", 32'(grant), 32'h0);
        check("t1_wait_c4", 32'(bpWait), 32'h1);
        check("t1_latch_c4", 32'(bcLatchEn), 32'h0);
        tick();
        check("t1_latch_c5", 32'(bcLatchEn), 32'h0);
        tick();
        check("t1_latch_c6", 32'(bcLatchEn), 32'h1);
        check("t1_wait_c6", 32'(bpWait), 32'h1);
        tick();
        check("t1_latch_c7", 32'(bcLatchEn), 32'h0);
        check("t1_wait_c7", 32'(bpWait), 32'h0);
`ifdef CAP_LOOP_STATS_EN
        check("t1_svcCnt", svcCnt, 32'd1);
`endif

        // T2: three channels together, back-to-back grants, one latch pulse
        doReset();
        en = 4'b1011;
        tick();
        check("t2_g0_a", 32'(grant), 32'h1);
        tick();
        check("t2_g0_b", 32'(grant), 32'h1);
        done = 4'b0001;
        tick();
        done = 4'b0000;
        en   = 4'b1010;
        check("t2_g1_a", 32'(grant), 32'h2);
        tick();
        check("t2_g1_b", 32'(grant), 32'h2);
        done = 4'b0010;
        tick();
        done = 4'b0000;
        en   = 4'b1000;
        check("t2_g3_a", 32'(grant), 32'h8);
        tick();
        check("t2_g3_b", 32'(grant), 32'h8);
        check("t2_nolatch_yet", 32'(latchCnt - latchBase), 32'd0);
        done = 4'b1000;
        tick();
        done = 4'b0000;
        en   = 4'b0000;
        check("t2_g_end", 32'(grant), 32'h0);
        ticks(4);
        check("t2_latch_once", 32'(latchCnt - latchBase), 32'd1);
        check("t2_wait_end", 32'(bpWait), 32'h0);
`ifdef CAP_LOOP_STATS_EN
        check("t2_svcCnt", svcCnt, 32'd3);
`endif

        // T3: serve ch1 to move the pointer to 2, then en=0101 arrives during GAP
        doReset();
        en = 4'b0010;
        tick();
        check("t3_g1", 32'(grant), 32'h2);
        done = 4'b0010;
        tick();
        done = 4'b0000;
        en   = 4'b0101;
        check("t3_gap", 32'(grant), 32'h0);
        tick();
        check("t3_g2_first", 32'(grant), 32'h4);
        check("t3_wait", 32'(bpWait), 32'h1);
        done = 4'b0100;
        tick();
        done = 4'b0001;
        en   = 4'b0001;
        check("t3_g0_second", 32'(grant), 32'h1);
        check("t3_nolatch_yet", 32'(latchCnt - latchBase), 32'd0);
        tick();
        done = 4'b0000;
        en   = 4'b0000;
        check("t3_g_end", 32'(grant), 32'h0);
        ticks(4);
        check("t3_latch_once", 32'(latchCnt - latchBase), 32'd1);
        check("t3_wait_end", 32'(bpWait), 32'h0);

        // T4: timeout on ch1 at grant+5, sticky until reset
        doReset();
        tmoLimit = 16'd5;
        en = 4'b0010;
        tick();
        check("t4_g1", 32'(grant), 32'h2);
        ticks(4);
        check("t4_nohalt_c4", 32'(bpHalt), 32'h0);
        check("t4_g1_c4", 32'(grant), 32'h2);
        tick();
        check("t4_halt", 32'(bpHalt), 32'h1);
        check("t4_tmoCh", 32'(tmoCh), 32'h1);
        check("t4_grant0", 32'(grant), 32'h0);
        check("t4_wait", 32'(bpWait), 32'h1);
        en   = 4'b1111;
        done = 4'b1111;
        ticks(3);
        check("t4_sticky_halt", 32'(bpHalt), 32'h1);
        check("t4_sticky_grant", 32'(grant), 32'h0);
        check("t4_sticky_wait", 32'(bpWait), 32'h1);
        check("t4_no_latch", 32'(latchCnt - latchBase), 32'd0);
        doReset();
        check("t4_rst_halt", 32'(bpHalt), 32'h0);
        check("t4_rst_wait", 32'(bpWait), 32'h0);

        // T5: done on the 5th cycle beats the timeout
        en = 4'b0001;
        tick();
        ticks(4);
        done = 4'b0001;
        tick();
        done = 4'b0000;
        en   = 4'b0000;
        check("t5_nohalt", 32'(bpHalt), 32'h0);
        check("t5_grant0", 32'(grant), 32'h0);
        ticks(4);
        check("t5_latch", 32'(latchCnt - latchBase), 32'd1);
        check("t5_nohalt_end", 32'(bpHalt), 32'h0);
        tmoLimit = 16'd0;

        // T6: reset mid-service aborts with no latch pulse
        doReset();
        en = 4'b0001;
        ticks(2);
        check("t6_grant_pre", 32'(grant), 32'h1);
        bRst = 1'b1;
        done = 4'b0001;
        tick();
        bRst = 1'b0;
        done = 4'b0000;
        en   = 4'b0000;
        check("t6_grant", 32'(grant), 32'h0);
        check("t6_wait", 32'(bpWait), 32'h0);
        check("t6_latchEn", 32'(bcLatchEn), 32'h0);
        ticks(4);
        check("t6_no_latch", 32'(latchCnt - latchBase), 32'd0);
`ifdef CAP_LOOP_STATS_EN
        check("t6_svcCnt", svcCnt, 32'd0);
`endif

        // T7: dropping en aborts the service; latch still follows
        doReset();
        en = 4'b0100;
        tick();
        check("t7_g2", 32'(grant), 32'h4);
        en = 4'b0000;
        tick();
        check("t7_abort", 32'(grant), 32'h0);
        ticks(4);
        check("t7_latch", 32'(latchCnt - latchBase), 32'd1);
`ifdef CAP_LOOP_STATS_EN
        check("t7_svcCnt", svcCnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
